// File: rtl/lane_sync_controller.sv
// +----------------------------------------------------------------------------+
// | lane_sync_controller                                                       |
// | Comma-based lane lock acquisition, payload forwarding, lock-loss tracking. |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module lane_sync_controller #(
    parameter logic [7:0] COMMA      = 8'hBC,
    parameter int         LOCK_COUNT = 4,
    parameter int         LOSS_COUNT = 3
) (
    input  logic       clk_4f,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid_in,
    input  logic       sym_err,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       active,
    output logic [3:0] err_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [0:0] ST_SEARCH = 1'b0;
    localparam logic [0:0] ST_LOCKED = 1'b1;
    localparam logic [3:0] C_LOCK    = 4'(LOCK_COUNT);
    localparam logic [3:0] C_LOSS    = 4'(LOSS_COUNT);

    logic [0:0] r_state;
    logic [0:0] w_state_next;
    logic [3:0] r_comma_cnt;
    logic [3:0] w_comma_next;
    logic [3:0] r_err_cnt;
    logic [3:0] w_err_next;
    logic [7:0] r_loss_cnt;
    logic [7:0] w_loss_next;
    logic [7:0] r_data_out;
    logic [7:0] w_data_next;
    logic       r_valid_out;
    logic       w_valid_next;
    logic       r_active;

    // sym_err takes priority over the comma compare
    logic       w_is_err;
    logic       w_is_comma;
    logic       w_is_payload;
    logic [3:0] w_comma_inc;
    logic [3:0] w_err_inc;
    logic       w_lock_hit;
    logic       w_loss_hit;

    assign w_is_err     = valid_in & sym_err;
    assign w_is_comma   = valid_in & ~sym_err & (data_in == COMMA);
    assign w_is_payload = valid_in & ~sym_err & (data_in != COMMA);
    assign w_comma_inc  = r_comma_cnt + 4'd1;
    assign w_err_inc    = r_err_cnt + 4'd1;
    assign w_lock_hit   = (r_state == ST_SEARCH) & w_is_comma & (w_comma_inc == C_LOCK);
    assign w_loss_hit   = (r_state == ST_LOCKED) & w_is_err & (w_err_inc == C_LOSS);

    always_ff @(posedge clk_4f) begin
        if (!reset) begin
            r_state     <= ST_SEARCH;
            r_comma_cnt <= 4'd0;
            r_err_cnt   <= 4'd0;
            r_loss_cnt  <= 8'd0;
            r_data_out  <= 8'd0;
            r_valid_out <= 1'b0;
            r_active    <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_comma_cnt <= w_comma_next;
            r_err_cnt   <= w_err_next;
            r_loss_cnt  <= w_loss_next;
            r_data_out  <= w_data_next;
            r_valid_out <= w_valid_next;
            r_active    <= (w_state_next == ST_LOCKED);
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_SEARCH: if (w_lock_hit) w_state_next = ST_LOCKED;
            ST_LOCKED: if (w_loss_hit) w_state_next = ST_SEARCH;
            default:   w_state_next = ST_SEARCH;
        endcase
    end

    always_comb begin
        w_comma_next = r_comma_cnt;
        w_err_next   = r_err_cnt;
        w_loss_next  = r_loss_cnt;
        w_data_next  = r_data_out;
        w_valid_next = 1'b0;
        case (r_state)
            ST_SEARCH: begin
                if (w_is_comma) begin
                    w_comma_next = w_lock_hit ? 4'd0 : w_comma_inc;
                    if (w_lock_hit) w_err_next = 4'd0;
                end else if (valid_in) begin
                    w_comma_next = 4'd0;
                end
            end
            ST_LOCKED: begin
                if (w_is_payload) begin
                    w_data_next  = data_in;
                    w_valid_next = 1'b1;
                    w_err_next   = 4'd0;
                end else if (w_is_comma) begin
                    w_err_next = 4'd0;
                end else if (w_is_err) begin
                    if (w_loss_hit) begin
                        // Exit byte never seeds a new comma run
                        w_err_next   = 4'd0;
                        w_comma_next = 4'd0;
                        w_loss_next  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;
                    end else begin
                        w_err_next = w_err_inc;
                    end
                end
            end
            default: begin
                w_comma_next = 4'd0;
                w_err_next   = 4'd0;
            end
        endcase
    end

    assign data_out      = r_data_out;
    assign valid_out     = r_valid_out;
    assign active        = r_active;
    assign err_cnt       = r_err_cnt;
    assign lock_loss_cnt = r_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_lane_sync_controller.sv
// +----------------------------------------------------------------------------+
// | tb_lane_sync_controller                                                    |
// | Directed and random stimulus against a behavioural lane-sync model.        |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_lane_sync_controller;

    localparam logic [7:0] COMMA      = 8'hBC;
    localparam int         LOCK_COUNT = 4;
    localparam int         LOSS_COUNT = 3;

    logic       clk_4f = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] data_in = 8'd0;
    logic       valid_in = 1'b0;
    logic       sym_err = 1'b0;
    logic [7:0] data_out;
    logic       valid_out;
    logic       active;
    logic [3:0] err_cnt;
    logic [7:0] lock_loss_cnt;

    int n_vec  = 0;
    int n_fail = 0;

    // Behavioural model: a lane is either hunting for commas or locked
    bit         m_locked;
    int         m_comma_run;
    int         m_err_run;
    int         m_losses;
    logic [7:0] m_dout;
    bit         m_vout;

    lane_sync_controller #(
        .COMMA(COMMA), .LOCK_COUNT(LOCK_COUNT), .LOSS_COUNT(LOSS_COUNT)
    ) dut (
        .clk_4f(clk_4f), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .sym_err(sym_err), .data_out(data_out), .valid_out(valid_out),
        .active(active), .err_cnt(err_cnt), .lock_loss_cnt(lock_loss_cnt)
    );

    always #5 clk_4f = ~clk_4f;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic rst_n, input logic v, input logic [7:0] d, input logic e);
        if (!rst_n) begin
            m_locked = 0; m_comma_run = 0; m_err_run = 0; m_losses = 0;
            m_dout = 8'd0; m_vout = 0;
        end else if (!v) begin
            m_vout = 0;
        end else if (!m_locked) begin
            m_vout = 0;
            if (!e && d == COMMA) begin
                m_comma_run++;
                if (m_comma_run == LOCK_COUNT) begin
                    m_locked = 1; m_comma_run = 0; m_err_run = 0;
                end
            end else begin
                m_comma_run = 0;
            end
        end else if (e) begin
            m_vout = 0;
            m_err_run++;
            if (m_err_run == LOSS_COUNT) begin
                m_locked = 0; m_err_run = 0; m_comma_run = 0;
                m_losses = (m_losses >= 255) ? 255 : m_losses + 1;
            end
        end else if (d == COMMA) begin
            m_vout = 0; m_err_run = 0;
        end else begin
            m_dout = d; m_vout = 1; m_err_run = 0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".active"},    32'(active),        32'(m_locked));
        chk({tag, ".valid_out"}, 32'(valid_out),     32'(m_vout));
        chk({tag, ".data_out"},  32'(data_out),      32'(m_dout));
        chk({tag, ".err_cnt"},   32'(err_cnt),       32'(m_err_run));
        chk({tag, ".loss_cnt"},  32'(lock_loss_cnt), 32'(m_losses));
    endtask

    task automatic step(input string tag, input logic rst_n, input logic v,
                        input logic [7:0] d, input logic e);
        @(negedge clk_4f);
        reset = rst_n; valid_in = v; data_in = d; sym_err = e;
        @(posedge clk_4f);
        model_edge(rst_n, v, d, e);
        #1;
        check_all(tag);
    endtask

    task automatic byte_in(input string tag, input logic [7:0] d);
        step(tag, 1'b1, 1'b1, d, 1'b0);
    endtask

    task automatic err_in(input string tag);
        step(tag, 1'b1, 1'b1, 8'h00, 1'b1);
    endtask

    task automatic do_reset(input string tag);
        step(tag, 1'b0, 1'b1, COMMA, 1'b0);
    endtask

    initial begin
        // Reset held for two edges while commas stream in
        do_reset("rst0");
        do_reset("rst1");
        chk("rst_active", 32'(active), 32'd0);
        chk("rst_valid",  32'(valid_out), 32'd0);
        for (int i = 0; i < 3; i++) byte_in("rst_relock", COMMA);
        chk("rst_3commas_no_lock", 32'(active), 32'd0);
        byte_in("rst_relock4", COMMA);
        chk("rst_4th_comma_locks", 32'(active), 32'd1);

        // Lock acquisition then back-to-back payload
        do_reset("acq_rst");
        byte_in("acq_ff", 8'hFF);
        for (int i = 0; i < 4; i++) byte_in("acq_comma", COMMA);
        chk("acq_active_rise", 32'(active), 32'd1);
        chk("acq_no_ff", 32'(valid_out), 32'd0);
        byte_in("acq_5a", 8'h5A);
        chk("acq_data_5a", 32'(data_out), 32'h5A);
        byte_in("acq_a5", 8'hA5);
        chk("acq_data_a5", 32'(data_out), 32'hA5);
        chk("acq_no_bubble", 32'(valid_out), 32'd1);

        // Broken comma run
        do_reset("brk_rst");
        for (int i = 0; i < 3; i++) byte_in("brk_c1", COMMA);
        byte_in("brk_ee", 8'hEE);
        for (int i = 0; i < 3; i++) byte_in("brk_c2", COMMA);
        chk("brk_not_locked", 32'(active), 32'd0);
        byte_in("brk_c3", COMMA);
        chk("brk_locked", 32'(active), 32'd1);

        // Comma filtering and idle gaps while locked
        byte_in("flt_11", 8'h11);
        chk("flt_11_pulse", 32'(valid_out), 32'd1);
        step("flt_idle", 1'b1, 1'b0, 8'h33, 1'b0);
        chk("flt_idle_nopulse", 32'(valid_out), 32'd0);
        byte_in("flt_bc", COMMA);
        chk("flt_bc_nopulse", 32'(valid_out), 32'd0);
        byte_in("flt_22", 8'h22);
        chk("flt_22_data", 32'(data_out), 32'h22);

        // Error runs and loss of lock
        err_in("los_e1");
        chk("los_err1", 32'(err_cnt), 32'd1);
        err_in("los_e2");
        byte_in("los_bc", COMMA);
        chk("los_err_clr", 32'(err_cnt), 32'd0);
        err_in("los_e3");
        step("los_gap", 1'b1, 1'b0, 8'h00, 1'b1);
        err_in("los_e4");
        chk("los_err2_active", 32'(active), 32'd1);
        err_in("los_e5");
        chk("los_drop", 32'(active), 32'd0);
        chk("los_cnt1", 32'(lock_loss_cnt), 32'd1);
        for (int i = 0; i < 4; i++) byte_in("los_relock", COMMA);
        chk("los_relocked", 32'(active), 32'd1);

        // Saturation of the lock-loss counter
        do_reset("sat_rst");
        for (int n = 1; n <= 256; n++) begin
            for (int i = 0; i < LOCK_COUNT; i++) byte_in("sat_c", COMMA);
            for (int i = 0; i < LOSS_COUNT; i++) err_in("sat_e");
            if (n >= 255) chk("sat_255", 32'(lock_loss_cnt), 32'd255);
        end

        // Reset mid error run clears everything on that edge
        for (int i = 0; i < LOCK_COUNT; i++) byte_in("mid_c", COMMA);
        err_in("mid_e1");
        err_in("mid_e2");
        chk("mid_err2", 32'(err_cnt), 32'd2);
        step("mid_rst", 1'b0, 1'b1, 8'h00, 1'b1);
        chk("mid_loss_clr", 32'(lock_loss_cnt), 32'd0);
        chk("mid_active_clr", 32'(active), 32'd0);

        // Randomized traffic, comma-heavy so the lane keeps locking and dropping
        for (int i = 0; i < 1500; i++) begin
            logic       r_v, r_e, r_rst;
            logic [7:0] r_d;
            r_rst = ($urandom_range(0, 299) != 0);
            r_v   = ($urandom_range(0, 99) < 85);
            r_e   = ($urandom_range(0, 99) < 12);
            r_d   = ($urandom_range(0, 99) < 45) ? COMMA : 8'($urandom_range(0, 255));
            step("rnd", r_rst, r_v, r_d, r_e);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
